// File: rtl/uart_rx_oversampled.sv
// uart_rx_oversampled: 16x-oversampled UART receiver with framing check and break hold-off
module uart_rx_oversampled #(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            rx,
  input  logic            s_tick,
  output logic [DBIT-1:0] dout,
  output logic            rx_done_tick,
  output logic            framing_err,
  output logic            busy
);
  localparam int SW = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;
  localparam int NW = $clog2(DBIT);
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] START = 3'd1;
  localparam logic [2:0] DATA  = 3'd2;
  localparam logic [2:0] STOP  = 3'd3;
  localparam logic [2:0] BRK   = 3'd4;
  localparam logic [SW-1:0] S_MID  = SW'(7);
  localparam logic [SW-1:0] S_END  = SW'(15);
  localparam logic [SW-1:0] S_STOP = SW'(SB_TICK - 1);
  localparam logic [NW-1:0] N_LAST = NW'(DBIT - 1);

  logic [1:0]      sync_q;
  logic            rx_s;
  logic [2:0]      state_q, state_d;
  logic [SW-1:0]   s_q, s_d;
  logic [NW-1:0]   n_q, n_d;
  logic [DBIT-1:0] b_q, b_d;
  logic [DBIT-1:0] dout_q, dout_d;
  logic            stop_q, stop_d;
  logic            stop_now;
  logic            done_q, done_d;
  logic            ferr_q, ferr_d;

  assign rx_s     = sync_q[1];
  // the stop sample may coincide with the final stop tick when SB_TICK is 8
  assign stop_now = (s_q == S_MID) ? rx_s : stop_q;

  // two-flop synchroniser for the asynchronous line, idles high
  always_ff @(posedge clk or negedge reset)
    if (!reset) sync_q <= 2'b11;
    else        sync_q <= {sync_q[0], rx};

  // frame sequencing: counters only move on oversampling ticks
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    b_d     = b_q;
    dout_d  = dout_q;
    stop_d  = stop_q;
    ferr_d  = ferr_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE:
        if (!rx_s) begin
          state_d = START;
          s_d     = '0;
        end
      START:
        if (s_tick) begin
          if (s_q == S_MID) begin
            state_d = rx_s ? IDLE : DATA;
            s_d     = '0;
            n_d     = '0;
          end else s_d = s_q + 1'b1;
        end
      DATA:
        if (s_tick) begin
          if (s_q == S_END) begin
            s_d     = '0;
            b_d     = {rx_s, b_q[DBIT-1:1]};
            state_d = (n_q == N_LAST) ? STOP : DATA;
            n_d     = (n_q == N_LAST) ? n_q : n_q + 1'b1;
          end else s_d = s_q + 1'b1;
        end
      STOP:
        if (s_tick) begin
          stop_d = stop_now;
          if (s_q == S_STOP) begin
            dout_d  = b_q;
            ferr_d  = ~stop_now;
            done_d  = 1'b1;
            s_d     = '0;
            state_d = stop_now ? IDLE : BRK;
          end else s_d = s_q + 1'b1;
        end
      BRK:
        if (rx_s) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // state, counters and held outputs
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q <= IDLE;
      s_q     <= '0;
      n_q     <= '0;
      b_q     <= '0;
      dout_q  <= '0;
      stop_q  <= 1'b0;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      n_q     <= n_d;
      b_q     <= b_d;
      dout_q  <= dout_d;
      stop_q  <= stop_d;
      done_q  <= done_d;
      ferr_q  <= ferr_d;
    end

  assign dout         = dout_q;
  assign rx_done_tick = done_q;
  assign framing_err  = ferr_q;
  assign busy         = state_q != IDLE;
endmodule

// File: tb/tb_uart_rx_oversampled.sv
// tb_uart_rx_oversampled: directed frames against two receiver configurations
module tb_uart_rx_oversampled;
  logic       clk = 1'b0, reset = 1'b0, rx1 = 1'b1, rx2 = 1'b1, s_tick = 1'b0;
  logic [7:0] dout1;
  logic [6:0] dout2;
  logic       done1, done2, ferr1, ferr2, busy1, busy2;
  int         cyc = 0, edge_cyc = 0, frame_c0 = 0, n_chk = 0, n_pass = 0, nd1 = 0, nd2 = 0;
  logic [7:0] dlog1 [64];
  logic [6:0] dlog2 [64];
  logic       flog1 [64];
  logic       flog2 [64];
  int         clog1 [64];
  int         clog2 [64];

  uart_rx_oversampled u_dut1 (
    .clk(clk), .reset(reset), .rx(rx1), .s_tick(s_tick),
    .dout(dout1), .rx_done_tick(done1), .framing_err(ferr1), .busy(busy1)
  );

  uart_rx_oversampled #(.DBIT(7), .SB_TICK(32)) u_dut2 (
    .clk(clk), .reset(reset), .rx(rx2), .s_tick(s_tick),
    .dout(dout2), .rx_done_tick(done2), .framing_err(ferr2), .busy(busy2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // log every completion strobe with the word and flag present while it is high
  always @(negedge clk) begin
    if (done1 && nd1 < 64) begin
      dlog1[nd1] = dout1; flog1[nd1] = ferr1; clog1[nd1] = cyc; nd1++;
    end
    if (done2 && nd2 < 64) begin
      dlog2[nd2] = dout2; flog2[nd2] = ferr2; clog2[nd2] = cyc; nd2++;
    end
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // one tick period of 4 clocks; the line changes 2.5 clocks before the next tick
  task automatic tp(input logic sel, input logic r);
    @(negedge clk) s_tick = 1'b1;
    @(negedge clk) s_tick = 1'b0;
    @(negedge clk) begin
      rx1 = sel ? 1'b1 : r;
      rx2 = sel ? r : 1'b1;
      edge_cyc = cyc;
    end
    @(negedge clk);
    #1;
  endtask

  task automatic seg(input logic sel, input logic r, input int n);
    repeat (n) tp(sel, r);
  endtask

  task automatic send_frame(input logic sel, input logic [8:0] d, input int nb, input logic stop, input int sb);
    seg(sel, 1'b0, 1);
    frame_c0 = edge_cyc;
    seg(sel, 1'b0, 15);
    for (int i = 0; i < nb; i++) seg(sel, d[i], 16);
    seg(sel, stop, sb);
  endtask

  initial begin
    logic [7:0] f5a;
    f5a = 8'h5A;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_dout", dout1, 0);
    chk("rst_done", done1, 0);
    chk("rst_ferr", ferr1, 0);
    chk("rst_busy", busy1, 0);
    chk("rst_dout2", dout2, 0);
    chk("rst_busy2", busy2, 0);
    reset = 1'b1;
    seg(0, 1'b1, 4);

    send_frame(0, 9'h0A5, 8, 1'b1, 16);
    seg(0, 1'b1, 4);
    chk("a5_cnt", nd1, 1);
    chk("a5_dout", dlog1[0], 8'hA5);
    chk("a5_ferr", flog1[0], 0);
    chk("a5_lat", clog1[0] - frame_c0, 611);
    chk("a5_busy", busy1, 0);
    chk("a5_hold", dout1, 8'hA5);

    send_frame(0, 9'h000, 8, 1'b1, 16);
    send_frame(0, 9'h0FF, 8, 1'b1, 16);
    seg(0, 1'b1, 4);
    chk("b2b_cnt", nd1, 3);
    chk("b2b_d0", dlog1[1], 8'h00);
    chk("b2b_f0", flog1[1], 0);
    chk("b2b_d1", dlog1[2], 8'hFF);
    chk("b2b_f1", flog1[2], 0);
    chk("b2b_gap", clog1[2] - clog1[1], 640);

    seg(0, 1'b0, 3);
    chk("glitch_busy", busy1, 1);
    seg(0, 1'b1, 20);
    chk("glitch_idle", busy1, 0);
    chk("glitch_cnt", nd1, 3);
    chk("glitch_dout", dout1, 8'hFF);
    send_frame(0, 9'h03C, 8, 1'b1, 16);
    seg(0, 1'b1, 4);
    chk("post_glitch_cnt", nd1, 4);
    chk("post_glitch_dout", dlog1[3], 8'h3C);
    chk("post_glitch_ferr", flog1[3], 0);

    send_frame(0, 9'h03C, 8, 1'b0, 16);
    seg(0, 1'b0, 40);
    chk("brk_cnt", nd1, 5);
    chk("brk_dout", dlog1[4], 8'h3C);
    chk("brk_ferr", flog1[4], 1);
    chk("brk_busy", busy1, 1);
    chk("brk_ferr_hold", ferr1, 1);
    seg(0, 1'b1, 4);
    chk("brk_exit", busy1, 0);
    chk("brk_no_extra", nd1, 5);
    send_frame(0, 9'h081, 8, 1'b1, 16);
    seg(0, 1'b1, 4);
    chk("after_brk_cnt", nd1, 6);
    chk("after_brk_dout", dlog1[5], 8'h81);
    chk("after_brk_ferr", ferr1, 0);

    seg(0, 1'b0, 16);
    for (int i = 0; i < 4; i++) seg(0, f5a[i], 16);
    seg(0, f5a[4], 8);
    reset = 1'b0;
    #1;
    chk("mid_rst_dout", dout1, 0);
    chk("mid_rst_ferr", ferr1, 0);
    chk("mid_rst_busy", busy1, 0);
    chk("mid_rst_done", done1, 0);
    seg(0, f5a[4], 8);
    for (int i = 5; i < 8; i++) seg(0, f5a[i], 16);
    seg(0, 1'b1, 20);
    chk("mid_rst_no_pulse", nd1, 6);
    reset = 1'b1;
    seg(0, 1'b1, 4);
    send_frame(0, 9'h012, 8, 1'b1, 16);
    seg(0, 1'b1, 4);
    chk("post_rst_cnt", nd1, 7);
    chk("post_rst_dout", dlog1[6], 8'h12);
    chk("post_rst_hold", dout1, 8'h12);

    send_frame(1, 9'h055, 7, 1'b1, 32);
    seg(1, 1'b1, 4);
    chk("sb32_cnt", nd2, 1);
    chk("sb32_dout", dlog2[0], 7'h55);
    chk("sb32_ferr", flog2[0], 0);
    chk("sb32_lat", clog2[0] - frame_c0, 611);
    chk("sb32_busy", busy2, 0);
    chk("sb32_other_quiet", nd1, 7);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
